max_pooling_fprop2_mul_pipe: RTL and testbench

Parametrised, pipelined signed multiplier for the fprop datapath. It computes din0*din1 and offers three output treatments on the full-precision product: a fixed-point right shift, round-half-up, and saturate or wrap. A valid/ready handshake supports backpressure. It is the successor to the combinational mul cores and is dropped between the pooling/accumulate stages wherever timing needs registered multiplies.

---
 rtl/max_pooling_fprop2_mul_pipe_pkg.sv | 56 +++++
 rtl/max_pooling_fprop2_mul_pipe_if.sv | 27 ++
 rtl/max_pooling_fprop2_mul_pipe_rndsat.sv | 30 +++
 rtl/max_pooling_fprop2_mul_pipe.sv | 147 ++++++++++++++
 tb/tb_max_pooling_fprop2_mul_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/max_pooling_fprop2_mul_pipe_pkg.sv
// Shared definitions for the fprop pipelined multiplier: stage limit, overflow
// mode and the shift / round-half-up / saturate-or-wrap helper.
package max_pooling_fprop2_pkg;

    localparam int MUL_MAX_STAGE = 8;
    // Widest product the helper handles; the result is carried in one extra bit.
    localparam int MUL_MAX_W     = 64;

    typedef enum logic [0:0] {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_e;

    typedef struct packed {
        logic [MUL_MAX_W-1:0] res;
        logic                 ovf;
    } sat_res_t;

    // Round-half-up right shift of a sign-extended product, then range check
    // against a dout_w-bit signed result. res holds the value to keep; the
    // caller takes its low dout_w bits (which is the wrap behaviour).
    function automatic sat_res_t sat_round(
        input logic signed [MUL_MAX_W-1:0] p,
        input int                          frac_shift,
        input int                          dout_w,
        input ovf_mode_e                   mode
    );
        logic signed [MUL_MAX_W:0] one_v;
        logic signed [MUL_MAX_W:0] ext_v;
        logic signed [MUL_MAX_W:0] rnd_v;
        logic signed [MUL_MAX_W:0] max_v;
        logic signed [MUL_MAX_W:0] min_v;
        sat_res_t                  out_v;
        one_v = {{MUL_MAX_W{1'b0}}, 1'b1};
        ext_v = {p[MUL_MAX_W-1], p};
        if (frac_shift > 32'sd0) begin
            rnd_v = (ext_v + (one_v <<< (frac_shift - 32'sd1))) >>> frac_shift;
        end else begin
            rnd_v = ext_v;
        end
        max_v = (one_v <<< (dout_w - 32'sd1)) - one_v;
        min_v = -(one_v <<< (dout_w - 32'sd1));
        out_v.ovf = (rnd_v > max_v) || (rnd_v < min_v);
        if (out_v.ovf && (mode == OVF_SAT)) begin
            if (rnd_v[MUL_MAX_W]) begin
                out_v.res = min_v[MUL_MAX_W-1:0];
            end else begin
                out_v.res = max_v[MUL_MAX_W-1:0];
            end
        end else begin
            out_v.res = rnd_v[MUL_MAX_W-1:0];
        end
        return out_v;
    endfunction

endpackage

// File: rtl/max_pooling_fprop2_mul_pipe_if.sv
// Operand / result handshake bundle for the pipelined multiplier.
// master = producer/consumer around the block, slave = the multiplier.
interface max_pooling_fprop2_mul_pipe_if #(
    parameter int A_W = 16,
    parameter int B_W = 16,
    parameter int D_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [A_W-1:0] din0;
    logic signed [B_W-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [D_W-1:0] dout;
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output in_valid, din0, din1, out_ready, ovf_clr,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready, ovf_clr,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/max_pooling_fprop2_mul_pipe_rndsat.sv
// Combinational shift / round / saturate unit placed in front of the last
// pipeline register. Purely a wrapper around the package helper.
module max_pooling_fprop2_mul_rndsat
    import max_pooling_fprop2_pkg::*;
#(
    parameter int W          = 32,
    parameter int D_W        = 16,
    parameter int FRAC_SHIFT = 0,
    parameter int SAT_EN     = 0
) (
    input  logic signed [W-1:0]   p_i,
    output logic signed [D_W-1:0] res_o,
    output logic                  ovf_o
);
    localparam ovf_mode_e MODE = (SAT_EN != 0) ? OVF_SAT : OVF_WRAP;

    logic signed [MUL_MAX_W-1:0] p_ext_s;
    sat_res_t                    sr_s;

    assign p_ext_s = MUL_MAX_W'(p_i);
    assign sr_s    = sat_round(p_ext_s, FRAC_SHIFT, D_W, MODE);
    assign res_o   = sr_s.res[D_W-1:0];
    assign ovf_o   = sr_s.ovf;

    // Upper result bits are only meaningful to the helper's own range logic.
    if (D_W < MUL_MAX_W) begin : g_hi
        logic unused_hi_s;
        assign unused_hi_s = ^sr_s.res[MUL_MAX_W-1:D_W];
    end
endmodule

// File: rtl/max_pooling_fprop2_mul_pipe.sv
// Pipelined signed multiplier with valid/ready backpressure. Stage 1 holds the
// full product, middle stages carry it, the last stage registers the shifted,
// rounded and saturated/wrapped result. Whole pipe freezes when blocked.
module max_pooling_fprop2_mul_pipe
    import max_pooling_fprop2_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 16,
    parameter int FRAC_SHIFT = 0,
    parameter int SAT_EN     = 0
) (
    input logic                          ap_clk,
    input logic                          ap_rst_n,
    max_pooling_fprop2_mul_pipe_if.slave bus
);
    localparam int W = din0_WIDTH + din1_WIDTH;

    if ((NUM_STAGE < 1) || (NUM_STAGE > MUL_MAX_STAGE) || (dout_WIDTH > W) ||
        (W > MUL_MAX_W) || (FRAC_SHIFT < 0) || (FRAC_SHIFT > W - 1) || (ID < 0)) begin : g_param_err
        $error("max_pooling_fprop2_mul_pipe: illegal parameter combination");
    end

    logic                         advance_s;
    logic                         accept_s;
    logic                         feed_vld_s;
    logic                         load_out_s;
    logic signed [W-1:0]          prod_s;
    logic signed [W-1:0]          rnd_in_s;
    logic signed [dout_WIDTH-1:0] res_s;
    logic                         res_ovf_s;
    logic [NUM_STAGE-1:0]         vld_q;
    logic [NUM_STAGE-1:0]         vld_d;
    logic signed [dout_WIDTH-1:0] dout_q;
    logic signed [dout_WIDTH-1:0] dout_d;
    logic                         ovf_q;
    logic                         ovf_d;

    // Bubbles are kept in place: one global advance moves every stage at once.
    assign advance_s  = ~vld_q[NUM_STAGE-1] | bus.out_ready;
    assign accept_s   = bus.in_valid & advance_s;
    assign prod_s     = W'($signed(bus.din0)) * W'($signed(bus.din1));
    assign load_out_s = advance_s & feed_vld_s;

    if (NUM_STAGE == 1) begin : g_single
        // Single stage: multiply and round/saturate feed the output register directly.
        assign rnd_in_s   = prod_s;
        assign feed_vld_s = accept_s;

        // Valid shift for a one-deep pipe.
        always_comb begin
            vld_d = vld_q;
            if (advance_s) begin
                vld_d = accept_s;
            end else begin
                vld_d = vld_q;
            end
        end
    end else begin : g_multi
        logic signed [W-1:0] p_q [NUM_STAGE-1];

        assign rnd_in_s   = p_q[NUM_STAGE-2];
        assign feed_vld_s = vld_q[NUM_STAGE-2];

        // Valid bits shift one stage per advancing cycle, new entry from accept.
        always_comb begin
            vld_d = vld_q;
            if (advance_s) begin
                vld_d = {vld_q[NUM_STAGE-2:0], accept_s};
            end else begin
                vld_d = vld_q;
            end
        end

        // Stage 1 captures the full-precision product; data needs no reset.
        always_ff @(posedge ap_clk) begin
            if (advance_s) begin
                p_q[0] <= prod_s;
            end
        end

        for (genvar s = 1; s < NUM_STAGE - 1; s++) begin : g_stage
            // Middle stage carries the product forward when the pipe advances.
            always_ff @(posedge ap_clk) begin
                if (advance_s) begin
                    p_q[s] <= p_q[s-1];
                end
            end
        end
    end

    max_pooling_fprop2_mul_rndsat #(
        .W          (W),
        .D_W        (dout_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .SAT_EN     (SAT_EN)
    ) u_rndsat (
        .p_i   (rnd_in_s),
        .res_o (res_s),
        .ovf_o (res_ovf_s)
    );

    // Output data loads only with a real item; ovf set beats clear.
    always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (load_out_s) begin
            dout_d = res_s;
        end else begin
            dout_d = dout_q;
        end
        if (load_out_s && res_ovf_s) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Stage valid bits; reset discards everything in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= {NUM_STAGE{1'b0}};
        end else begin
            vld_q <= vld_d;
        end
    end

    // Registered result and sticky overflow flag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_q <= {dout_WIDTH{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.in_ready  = advance_s;
    assign bus.out_valid = vld_q[NUM_STAGE-1];
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_max_pooling_fprop2_mul_pipe.sv
// Bench: six multiplier configurations driven by one shared stimulus stream.
// Each has an item-level reference model (queue of results with their age in
// the pipe) checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_max_pooling_fprop2_mul_pipe;
    localparam int NCFG = 6;
    // cfg0 default, cfg1 saturate, cfg2 frac 8, cfg3 frac 1, cfg4 N=1, cfg5 N=8
    localparam int CFG_N   [NCFG] = '{3, 3, 3, 3, 1, 8};
    localparam int CFG_FS  [NCFG] = '{0, 0, 8, 1, 0, 0};
    localparam int CFG_SAT [NCFG] = '{0, 1, 0, 0, 0, 0};

    logic               ap_clk    = 1'b0;
    logic               ap_rst_n  = 1'b1;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b0;
    logic               ovf_clr   = 1'b0;
    logic signed [15:0] din0      = 16'sd0;
    logic signed [15:0] din1      = 16'sd0;

    int     checks = 0;
    int     errors = 0;
    int     dut_pops [NCFG];
    longint dut_sum  [NCFG];

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Plain-arithmetic statement of the result rules for a 16-bit dout.
    function automatic void model(input longint a, input longint b, input int fs, input int sat,
                                  output logic signed [15:0] r16, output bit ov);
        longint p;
        longint r;
        p = a * b;
        if (fs > 0) r = (p + (64'sd1 <<< (fs - 1))) >>> fs;
        else r = p;
        ov = (r > 64'sd32767) || (r < -64'sd32768);
        if (ov && (sat != 0)) r = (r < 0) ? -64'sd32768 : 64'sd32767;
        r16 = r[15:0];
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int N = CFG_N[g];

        max_pooling_fprop2_mul_pipe_if #(.A_W(16), .B_W(16), .D_W(16)) bus_if ();

        assign bus_if.in_valid  = in_valid;
        assign bus_if.din0      = din0;
        assign bus_if.din1      = din1;
        assign bus_if.out_ready = out_ready;
        assign bus_if.ovf_clr   = ovf_clr;

        max_pooling_fprop2_mul_pipe #(
            .ID(g + 1), .NUM_STAGE(N), .din0_WIDTH(16), .din1_WIDTH(16),
            .dout_WIDTH(16), .FRAC_SHIFT(CFG_FS[g]), .SAT_EN(CFG_SAT[g])
        ) dut (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .bus      (bus_if)
        );

        logic signed [15:0] q_val [$];
        bit                 q_ov  [$];
        int                 q_age [$];
        bit                 ovf_m = 1'b0;

        // Reference model: items age by one per advancing cycle, shown at age N.
        always @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                q_val.delete(); q_ov.delete(); q_age.delete();
                ovf_m = 1'b0;
            end else begin : mdl
                bit pres, adv, set_o, o;
                logic signed [15:0] v;
                pres  = (q_age.size() > 0) && (q_age[0] == N);
                adv   = !pres || out_ready;
                set_o = 1'b0;
                if (adv) begin
                    if (pres) begin
                        void'(q_val.pop_front()); void'(q_ov.pop_front()); void'(q_age.pop_front());
                    end
                    foreach (q_age[k]) q_age[k] = q_age[k] + 1;
                    if (in_valid) begin
                        model(din0, din1, CFG_FS[g], CFG_SAT[g], v, o);
                        q_val.push_back(v); q_ov.push_back(o); q_age.push_back(1);
                    end
                    if ((q_age.size() > 0) && (q_age[0] == N)) set_o = q_ov[0];
                end
                if (set_o) ovf_m = 1'b1;
                else if (ovf_clr) ovf_m = 1'b0;
            end
        end

        // Compare DUT against the model mid-cycle, and tally delivered results.
        always @(negedge ap_clk) begin
            if (ap_rst_n) begin : cmp
                bit pres;
                pres = (q_age.size() > 0) && (q_age[0] == N);
                chk($sformatf("cfg%0d out_valid", g), longint'(bus_if.out_valid), longint'(pres));
                chk($sformatf("cfg%0d in_ready", g), longint'(bus_if.in_ready), longint'(!pres || out_ready));
                chk($sformatf("cfg%0d ovf", g), longint'(bus_if.ovf), longint'(ovf_m));
                if (pres) chk($sformatf("cfg%0d dout", g), longint'(bus_if.dout), longint'(q_val[0]));
                if (bus_if.out_valid && out_ready) begin
                    dut_pops[g] = dut_pops[g] + 1;
                    dut_sum[g]  = dut_sum[g] + longint'(bus_if.dout);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic send_hold(input logic signed [15:0] a, input logic signed [15:0] b);
        out_ready = 1'b0; in_valid = 1'b1; din0 = a; din1 = b;
        cyc(1);
        in_valid = 1'b0;
        cyc(10);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat_a, lat_e, lat_f, idx, c, s0;
        longint m0;
        bit acc, found;
        logic [12:0] ov_a, ov_e, ov_f;
        logic [3:0] pat;

        // Reset state
        #2 ap_rst_n = 1'b0;
        cyc(2);
        chk("rst out_valid", longint'(g_cfg[0].bus_if.out_valid), 0);
        chk("rst dout", longint'(g_cfg[0].bus_if.dout), 0);
        chk("rst ovf", longint'(g_cfg[0].bus_if.ovf), 0);
        @(negedge ap_clk); #1 ap_rst_n = 1'b1;
        cyc(1);

        // Latency: single beat 300*200, held at output
        out_ready = 1'b0; in_valid = 1'b1; din0 = 16'sd300; din1 = 16'sd200;
        cyc(1);
        in_valid = 1'b0;
        lat_a = -1; lat_e = -1; lat_f = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge ap_clk);
            if (lat_a < 0 && g_cfg[0].bus_if.out_valid) lat_a = k;
            if (lat_e < 0 && g_cfg[4].bus_if.out_valid) lat_e = k;
            if (lat_f < 0 && g_cfg[5].bus_if.out_valid) lat_f = k;
        end
        chk("latency N3", lat_a, 3);
        chk("latency N1", lat_e, 1);
        chk("latency N8", lat_f, 8);
        @(posedge ap_clk); #1;
        chk("wrap 300x200", longint'(g_cfg[0].bus_if.dout), -64'sd5536);
        chk("wrap ovf", longint'(g_cfg[0].bus_if.ovf), 1);
        chk("sat max", longint'(g_cfg[1].bus_if.dout), 64'sd32767);
        chk("sat ovf", longint'(g_cfg[1].bus_if.ovf), 1);
        drain();

        // Negative saturation / wrap, then ovf_clr
        send_hold(-16'sd300, 16'sd200);
        chk("sat min", longint'(g_cfg[1].bus_if.dout), -64'sd32768);
        chk("wrap -300x200", longint'(g_cfg[0].bus_if.dout), 64'sd5536);
        drain();
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf cleared", longint'(g_cfg[1].bus_if.ovf), 0);

        // ovf_clr held while a new overflowing result is presented: set wins
        ovf_clr = 1'b1; in_valid = 1'b1; din0 = 16'sd300; din1 = 16'sd200;
        cyc(1);
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge ap_clk);
            if (g_cfg[1].bus_if.out_valid) found = 1'b1;
        end
        chk("set-vs-clr present", longint'(found), 1);
        chk("set-vs-clr ovf", longint'(g_cfg[1].bus_if.ovf), 1);
        @(posedge ap_clk); #1 ovf_clr = 1'b0;
        drain();

        // Fixed-point rounding
        send_hold(16'sh0180, 16'sh0100);
        chk("frac8 384", longint'(g_cfg[2].bus_if.dout), 64'sd384);
        drain();
        send_hold(16'sd3, -16'sd1);
        chk("frac1 3x-1", longint'(g_cfg[3].bus_if.dout), -64'sd1);
        drain();
        send_hold(16'sd3, 16'sd1);
        chk("frac1 3x1", longint'(g_cfg[3].bus_if.dout), 64'sd2);
        drain();
        cyc(10);

        // Backpressure: stream 0..19 x 1, out_ready low for cycles 5..9
        s0 = dut_pops[0]; m0 = dut_sum[0];
        idx = 0; c = 0;
        while (idx < 20 && c < 200) begin
            out_ready = !(c >= 5 && c <= 9);
            in_valid = 1'b1; din0 = 16'(idx); din1 = 16'sd1;
            @(negedge ap_clk);
            acc = g_cfg[0].bus_if.in_ready;
            @(posedge ap_clk); #1;
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(20);
        chk("stream accepted", idx, 20);
        chk("stream delivered", dut_pops[0] - s0, 20);
        chk("stream sum", dut_sum[0] - m0, 190);

        // Bubbles: in_valid 1,0,1,1 with out_ready high
        pat = 4'b1101;
        for (int k = 0; k < 13; k++) begin
            in_valid = (k < 4) ? pat[k] : 1'b0;
            din0 = 16'(k + 5); din1 = 16'sd7;
            @(negedge ap_clk);
            ov_a[k] = g_cfg[0].bus_if.out_valid;
            ov_e[k] = g_cfg[4].bus_if.out_valid;
            ov_f[k] = g_cfg[5].bus_if.out_valid;
            @(posedge ap_clk); #1;
        end
        in_valid = 1'b0;
        chk("bubble N3", longint'(ov_a), 104);
        chk("bubble N1", longint'(ov_e), 26);
        chk("bubble N8", longint'(ov_f), 3328);
        cyc(12);

        // Reset mid-stream with three overflowing items in flight
        s0 = dut_pops[0];
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; din0 = 16'sd300; din1 = 16'(200 + k);
            cyc(1);
        end
        in_valid = 1'b0;
        chk("pre-rst out_valid", longint'(g_cfg[0].bus_if.out_valid), 1);
        chk("pre-rst ovf", longint'(g_cfg[0].bus_if.ovf), 1);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", longint'(g_cfg[0].bus_if.out_valid), 0);
        chk("mid-rst dout", longint'(g_cfg[0].bus_if.dout), 0);
        chk("mid-rst ovf", longint'(g_cfg[0].bus_if.ovf), 0);
        #1 ap_rst_n = 1'b1;
        cyc(20);
        chk("post-rst no output", dut_pops[0] - s0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
